// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives every N_IN-bit input combination, in binary or
// Gray order, into a DUT and its reference model. Each vector is held for
// DWELL cycles. On the last cycle of each hold, the two responses are
// compared. Results: pass/fail, a saturating error count, and the first
// failing vector.
//
// Control protocol (there is no valid/ready pair on this block):
//   start - single-cycle request. It is sampled only in IDLE or DONE.
//           While a sweep is running it is ignored.
//   abort - takes effect on the next rising edge in any state.
//           It wins over start and over a check on the same edge.
//   busy  - high for exactly 2^N_IN * DWELL cycles per completed sweep.
//   done  - rises on the edge where busy falls. It stays high until the
//           next start, abort or reset.
module truth_table_sweep #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int DWELL = 100,
    parameter int GRAY  = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  first_fail,
    output logic [1:0]       state_dbg
);

    // A dwell of 1 still needs a one-bit counter, which stays at zero.
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]   IDX_LAST  = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   idx;
    logic [N_IN-1:0]   idx_nxt;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic [N_IN-1:0]   stim_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              pass_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic              fv_nxt;
    logic [N_IN-1:0]   ff_nxt;

    logic              mismatch;
    logic [ERR_W-1:0]  err_bumped;
    logic [N_IN-1:0]   idx_inc;

    // Map a sweep index to the vector that is actually presented.
    function automatic logic [N_IN-1:0] vec(input logic [N_IN-1:0] i);
        if (GRAY != 0) begin
            return i ^ (i >> 1);
        end
        return i;
    endfunction

    assign state_dbg = state;

    // Compare helpers. The count only moves when it is not yet saturated.
    always_comb begin
        mismatch   = (dut_out != exp_out);
        idx_inc    = idx + 1'b1;
        err_bumped = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_bumped = err_count + 1'b1;
        end
    end

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dcnt_nxt  = dcnt;
        stim_nxt  = stim;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err_count;
        fv_nxt    = fail_valid;
        ff_nxt    = first_fail;

        if (abort) begin
            // Partial error results are kept so a caller can still inspect them.
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            dcnt_nxt  = '0;
            stim_nxt  = '0;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt = S_APPLY;
                        idx_nxt   = '0;
                        dcnt_nxt  = '0;
                        stim_nxt  = vec('0);
                        done_nxt  = 1'b0;
                        pass_nxt  = 1'b0;
                        err_nxt   = '0;
                        fv_nxt    = 1'b0;
                        ff_nxt    = '0;
                    end
                end
                S_APPLY: begin
                    if (dcnt != DCNT_LAST) begin
                        dcnt_nxt = dcnt + 1'b1;
                    end else begin
                        // Check edge: the responses to stim have settled by now.
                        err_nxt = err_bumped;
                        if (mismatch && !fail_valid) begin
                            fv_nxt = 1'b1;
                            ff_nxt = stim;
                        end
                        if (idx != IDX_LAST) begin
                            idx_nxt  = idx_inc;
                            dcnt_nxt = '0;
                            stim_nxt = vec(idx_inc);
                        end else begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                            pass_nxt  = (err_bumped == '0);
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    stim_nxt  = '0;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end
            endcase
        end

        busy_nxt = (state_nxt == S_APPLY);
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            dcnt       <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            dcnt       <= dcnt_nxt;
            stim       <= stim_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_valid <= fv_nxt;
            first_fail <= ff_nxt;
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep. It uses two instances:
//   a: binary order, DWELL=4, ERR_W=8, with selectable per-vector faults.
//   b: Gray order, DWELL=1, ERR_W=2, with a DUT that always mismatches.
// A cycle-count model predicts every output on every edge.
// Directed tests then pin key results to literal values.
module tb_truth_table_sweep;

    logic clk;
    logic rst_n;
    logic check_en;

    logic       start_a, abort_a;
    logic [1:0] dut_a, exp_a;
    logic [2:0] stim_a, ff_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [7:0] err_a;
    logic [1:0] st_a;
    logic [7:0] fault_a;

    logic       start_b, abort_b;
    logic [1:0] dut_b, exp_b;
    logic [2:0] stim_b, ff_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [1:0] err_b;
    logic [1:0] st_b;

    int n_checks;
    int n_pass;

    typedef struct {
        bit busy;
        bit done;
        bit pass;
        bit fv;
        int err;
        int ff;
        int stim;
        int t;
    } model_t;

    model_t ma, mb;

    // Arbitrary combinational reference function of the stimulus.
    function automatic logic [1:0] ref_fn(input logic [2:0] s);
        return {s[1] & s[2], s[0] ^ s[2]};
    endfunction

    assign exp_a = ref_fn(stim_a);
    assign dut_a = exp_a ^ {1'b0, fault_a[stim_a]};
    assign exp_b = ref_fn(stim_b);
    assign dut_b = ~exp_b;

    truth_table_sweep #(.N_IN(3), .N_OUT(2), .DWELL(4), .GRAY(0), .ERR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .dut_out(dut_a), .exp_out(exp_a), .stim(stim_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
        .first_fail(ff_a), .state_dbg(st_a)
    );

    truth_table_sweep #(.N_IN(3), .N_OUT(2), .DWELL(1), .GRAY(1), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_out(dut_b), .exp_out(exp_b), .stim(stim_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
        .first_fail(ff_b), .state_dbg(st_b)
    );

    // Clock and global watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int vec_of(input int i, input bit gray);
        return gray ? (i ^ (i >> 1)) : i;
    endfunction

    // Model: position in the sweep is a plain cycle count t.
    // The vector on show is vec(t / dwell), and checks fall on the last cycle of each dwell.
    task automatic model_step(inout model_t m, input bit ab, input bit st, input bit mis,
                              input int dwell, input int nvec, input int err_max, input bit gray);
        if (ab) begin
            m.busy = 0; m.done = 0; m.pass = 0; m.stim = 0;
        end else if (!m.busy) begin
            if (st) begin
                m.busy = 1; m.done = 0; m.pass = 0;
                m.err = 0; m.fv = 0; m.ff = 0; m.t = 0;
                m.stim = vec_of(0, gray);
            end
        end else begin
            if ((m.t % dwell) == dwell - 1 && mis) begin
                if (m.err < err_max) m.err++;
                if (!m.fv) begin
                    m.fv = 1;
                    m.ff = m.stim;
                end
            end
            if (m.t == nvec * dwell - 1) begin
                m.busy = 0; m.done = 1; m.pass = (m.err == 0);
            end else begin
                m.t++;
                m.stim = vec_of(m.t / dwell, gray);
            end
        end
    endtask

    // Compare process: advance both models on each edge or reset, then check 1ns later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            model_step(ma, abort_a, start_a, dut_a != exp_a, 4, 8, 255, 1'b0);
            model_step(mb, abort_b, start_b, dut_b != exp_b, 1, 8, 3, 1'b1);
        end
        #1;
        if (check_en) begin
            check("m_stim_a", stim_a, ma.stim);
            check("m_busy_a", busy_a, ma.busy);
            check("m_done_a", done_a, ma.done);
            check("m_pass_a", pass_a, ma.pass);
            check("m_err_a", err_a, ma.err);
            check("m_fv_a", fv_a, ma.fv);
            check("m_ff_a", ff_a, ma.ff);
            check("m_stim_b", stim_b, mb.stim);
            check("m_busy_b", busy_b, mb.busy);
            check("m_done_b", done_b, mb.done);
            check("m_pass_b", pass_b, mb.pass);
            check("m_err_b", err_b, mb.err);
            check("m_fv_b", fv_b, mb.fv);
            check("m_ff_b", ff_b, mb.ff);
        end
    end

    // Driver tasks. Inputs change only on falling edges.
    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    // Counts busy cycles until done. Optionally pokes start at iteration poke_at.
    task automatic wait_done_a(input int poke_at, output int busy_cyc);
        bit got;
        got = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_a) begin
                got = 1'b1;
                break;
            end
            if (busy_a) busy_cyc++;
            start_a = (i == poke_at);
            @(negedge clk);
        end
        start_a = 1'b0;
        check("done_a_reached", got, 1);
    endtask

    task automatic wait_stim_a(input logic [2:0] v);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (stim_a == v) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stim_a_reached", got, 1);
    endtask

    // Directed sequence with literal expectations.
    initial begin
        int bc;
        int gray_ref[8];
        logic [2:0] stim_q[$];
        bit got_b;

        gray_ref = '{0, 1, 3, 2, 6, 7, 5, 4};
        n_checks = 0;
        n_pass = 0;
        check_en = 1'b0;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; fault_a = 8'h00;
        start_b = 1'b0; abort_b = 1'b0;

        repeat (2) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_fv", fv_a, 0);
        check("rst_ff", ff_a, 0);
        rst_n = 1'b1;

        // Clean sweep.
        pulse_start_a();
        wait_done_a(-1, bc);
        check("clean_busy_cycles", bc, 32);
        check("clean_pass", pass_a, 1);
        check("clean_err", err_a, 0);
        check("clean_fv", fv_a, 0);
        check("clean_stim_last", stim_a, 7);

        // Back-to-back sweep with faults on vectors 5 and 6.
        fault_a = 8'b0110_0000;
        pulse_start_a();
        wait_done_a(-1, bc);
        check("fault_busy_cycles", bc, 32);
        check("fault_err", err_a, 2);
        check("fault_fv", fv_a, 1);
        check("fault_ff", ff_a, 5);
        check("fault_pass", pass_a, 0);
        check("fault_done", done_a, 1);

        // A start pulse mid-sweep is ignored.
        fault_a = 8'h00;
        pulse_start_a();
        wait_done_a(10, bc);
        check("poke_busy_cycles", bc, 32);
        check("poke_pass", pass_a, 1);

        // Abort while stim=3. The partial error from vector 1 is kept.
        fault_a = 8'b0000_0010;
        pulse_start_a();
        wait_stim_a(3'd3);
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        check("abort_stim", stim_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_pass", pass_a, 0);
        check("abort_err", err_a, 1);
        check("abort_fv", fv_a, 1);
        check("abort_ff", ff_a, 1);

        // A fresh sweep after abort starts with cleared counts.
        fault_a = 8'h00;
        pulse_start_a();
        check("fresh_err_cleared", err_a, 0);
        check("fresh_fv_cleared", fv_a, 0);
        wait_done_a(-1, bc);
        check("fresh_busy_cycles", bc, 32);
        check("fresh_pass", pass_a, 1);

        // Gray order with DWELL=1: every vector mismatches, so the 2-bit count saturates.
        pulse_start_b();
        got_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done_b) begin
                got_b = 1'b1;
                break;
            end
            if (busy_b) stim_q.push_back(stim_b);
            @(negedge clk);
        end
        check("done_b_reached", got_b, 1);
        check("gray_len", stim_q.size(), 8);
        for (int i = 0; i < stim_q.size() && i < 8; i++) begin
            check("gray_vec", stim_q[i], gray_ref[i]);
            if (i > 0) check("gray_onebit", $countones(stim_q[i] ^ stim_q[i-1]), 1);
        end
        check("sat_err", err_b, 3);
        check("sat_pass", pass_b, 0);
        check("sat_fv", fv_b, 1);
        check("sat_ff", ff_b, 0);

        // Reset mid-sweep at stim=2. Outputs must clear without a clock edge.
        fault_a = 8'b0000_0001;
        pulse_start_a();
        wait_stim_a(3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_stim", stim_a, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        check("mrst_pass", pass_a, 0);
        check("mrst_err", err_a, 0);
        check("mrst_fv", fv_a, 0);
        check("mrst_ff", ff_a, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_no_done", done_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Synthesizable, parametrised exhaustive-stimulus sequencer with built-in checking. It steps an N_IN-bit input vector through all 2^N_IN combinations in binary or Gray order and holds each for a programmable dwell. On the last dwell cycle it compares the device-under-test outputs against a golden reference model's outputs, then reports pass/fail, an error count and the first failing vector. It sits between a combinational DUT and its reference model, both driven by `stim`, replacing hand-written per-vector testbench sequences and enabling on-board self-test.

## Interface
- `N_IN`, default 3: stimulus width; sweeps 2^N_IN vectors (1..16).
- `N_OUT`, default 2: compared output width.
- `DWELL`, default 100: clock cycles each vector is held (>=1).
- `GRAY`, default 0: 0 = binary order, 1 = Gray-code order.
- `ERR_W`, default 8: error counter width (saturating).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin sweep; sampled in IDLE or DONE only.
- `abort`  in  1  terminate sweep, return to IDLE.
- `dut_out`  in  N_OUT  DUT response to `stim`.
- `exp_out`  in  N_OUT  reference-model response to `stim`.
- `stim`  out  N_IN  current stimulus vector (registered).
- `busy`  out  1  high while sweeping.
- `done`  out  1  high in DONE until next `start`/`abort`/reset.
- `pass`  out  1  valid when `done`=1; 1 iff `err_count`=0.
- `err_count`  out  ERR_W  mismatching vectors, saturates at 2^ERR_W-1.
- `fail_valid`  out  1  at least one mismatch seen this sweep.
- `first_fail`  out  N_IN  `stim` value of the first mismatch.

## Operation
- States: IDLE, APPLY, DONE.
- Reset (async): state IDLE; `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0; internal index `idx`=0, dwell counter `dcnt`=0.
- IDLE/DONE + `start`=1 → APPLY:
  - `idx`=0, `dcnt`=0; `stim`=vec(0).
  - `err_count`, `fail_valid`, `first_fail`, `pass`, `done` all cleared.
- vec(i) = i when GRAY=0; i ^ (i>>1) when GRAY=1.
- APPLY, `dcnt` < DWELL-1: increment `dcnt`; `stim` held.
- APPLY, `dcnt` = DWELL-1 (check edge):
  - Mismatch is `dut_out` != `exp_out`, full N_OUT-bit compare.
  - On mismatch, `err_count` increments unless saturated.
  - If `fail_valid`=0 on a mismatch, set `fail_valid`=1 and `first_fail`=`stim`.
  - If `idx` < 2^N_IN-1: `idx`+1, `dcnt`=0, `stim`=vec(`idx`+1).
  - Otherwise go to DONE; `pass`=1 iff the final error count, including this check, is 0.
- DONE: `stim` holds the last vector; results hold.
- `abort`=1 in any state → IDLE next edge. `stim`=0, `busy`=0, `done`=0, `pass`=0. `err_count`/`fail_valid`/`first_fail` keep their partial values. `abort` has priority over `start` and over the check edge; the check on an aborted edge is discarded.
- `start` while in APPLY is ignored.
- Reset mid-sweep: immediate return to the reset values above, with no completion and no `done`.

## Timing
- All outputs are registered; `busy` = (state==APPLY).
- `start` sampled at edge k → `stim`=vec(0) and `busy`=1 after edge k.
- Each vector is presented for exactly DWELL cycles.
- `dut_out`/`exp_out` are sampled at the final edge of each dwell. Both must settle combinationally within one cycle of a `stim` change.
- `busy` is high for exactly 2^N_IN × DWELL cycles. `done` rises on the same edge that `busy` falls.
- `err_count` updates on the check edge of the failing vector.
- Back-to-back sweeps: `start` in DONE restarts with no idle cycle.

## Test plan
- N_IN=3, DWELL=4, GRAY=0, `dut_out`=`exp_out` → `stim` 0..7, 4 cycles each; `busy` 32 cycles; `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- Same config; `dut_out` forced to differ only while `stim`=5 and `stim`=6 → `err_count`=2, `fail_valid`=1, `first_fail`=5, `pass`=0.
- GRAY=1, N_IN=3, DWELL=1 → `stim` sequence 0,1,3,2,6,7,5,4, exactly one bit changing per step; `busy` 8 cycles.
- ERR_W=2, all vectors mismatching → `err_count` saturates at 3; `pass`=0.
- Assert `abort` while `stim`=3 (DWELL=4) → IDLE next edge; `stim`=0, `busy`=0, `done`=0. A later `start` runs a full fresh sweep with counts cleared.
- Pulse `start` mid-sweep → ignored, total `busy` still 32 cycles. Drop `rst_n` low at `stim`=2 → all outputs reset immediately, with no clock edge required.
